// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg: legality check and stage-count derivation for the csel adder.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  function automatic bit blk_legal(input int width, input int block);
    return (block >= 1) && (block <= width) && ((width % block) == 0);
  endfunction

  function automatic int num_blk(input int width, input int block);
    return (block > 0) ? (width / block) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csel_block.sv
// ----------------------------------------------------------------------------
// csel_block: BLOCK-bit conditional-sum slice, two ripple chains and a mux.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_c_sel,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_c_out,
  output logic             o_c_msb
);

  logic [BLOCK:0]   w_c0;
  logic [BLOCK:0]   w_c1;
  logic [BLOCK-1:0] w_s0;
  logic [BLOCK-1:0] w_s1;

  assign w_c0[0] = 1'b0;
  assign w_c1[0] = 1'b1;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    full_adder u_fa0 (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_c0[i]),
      .o_s (w_s0[i]),
      .o_c (w_c0[i+1])
    );
    full_adder u_fa1 (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_c1[i]),
      .o_s (w_s1[i]),
      .o_c (w_c1[i+1])
    );
  end

  // Carry into the slice MSB rides along so the last stage can derive overflow.
  multiplexer #(.WIDTH(BLOCK + 2)) u_sel (
    .i_d0  ({w_c0[BLOCK-1], w_c0[BLOCK], w_s0}),
    .i_d1  ({w_c1[BLOCK-1], w_c1[BLOCK], w_s1}),
    .i_sel (i_c_sel),
    .o_y   ({o_c_msb, o_c_out, o_sum})
  );

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder: single-bit full adder cell.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

`default_nettype wire

// File: rtl/multiplexer.sv
// ----------------------------------------------------------------------------
// multiplexer: WIDTH-bit 2:1 mux cell.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multiplexer #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

`default_nettype wire

// File: rtl/pipelined_csel_adder.sv
// ----------------------------------------------------------------------------
// pipelined_csel_adder: valid/ready carry-select adder/subtractor, one slice
// resolved per stage. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipelined_csel_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NUM_BLK = num_blk(WIDTH, BLOCK);
  localparam int LAST    = NUM_BLK - 1;

  if (!blk_legal(WIDTH, BLOCK)) begin : g_bad_params
    $fatal(1, "pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic             w_advance;
  logic             w_cin_eff;
  logic [WIDTH-1:0] w_b_eff;

  logic [BLOCK-1:0] w_blk_a    [NUM_BLK];
  logic [BLOCK-1:0] w_blk_b    [NUM_BLK];
  logic [BLOCK-1:0] w_blk_sum  [NUM_BLK];
  logic             w_blk_sel  [NUM_BLK];
  logic             w_blk_cout [NUM_BLK];
  logic             w_blk_cmsb [NUM_BLK];

  logic             valid_q [NUM_BLK];
  logic             valid_d [NUM_BLK];
  logic [WIDTH-1:0] sum_q   [NUM_BLK];
  logic [WIDTH-1:0] sum_d   [NUM_BLK];
  logic             carry_q [NUM_BLK];
  logic             carry_d [NUM_BLK];
  logic             cmsb_q  [NUM_BLK];
  logic             cmsb_d  [NUM_BLK];
  logic [WIDTH-1:0] opa_q   [NUM_BLK];
  logic [WIDTH-1:0] opa_d   [NUM_BLK];
  logic [WIDTH-1:0] opb_q   [NUM_BLK];
  logic [WIDTH-1:0] opb_d   [NUM_BLK];

  assign out_valid = valid_q[LAST];
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;
  assign w_b_eff   = b ^ {WIDTH{sub}};
  assign w_cin_eff = c_in ^ sub;

  for (genvar s = 0; s < NUM_BLK; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign w_blk_a[s]   = a[BLOCK-1:0];
      assign w_blk_b[s]   = w_b_eff[BLOCK-1:0];
      assign w_blk_sel[s] = w_cin_eff;
    end else begin : g_body
      assign w_blk_a[s]   = opa_q[s-1][s*BLOCK +: BLOCK];
      assign w_blk_b[s]   = opb_q[s-1][s*BLOCK +: BLOCK];
      assign w_blk_sel[s] = carry_q[s-1];
    end

    csel_block #(.BLOCK(BLOCK)) u_blk (
      .i_a     (w_blk_a[s]),
      .i_b     (w_blk_b[s]),
      .i_c_sel (w_blk_sel[s]),
      .o_sum   (w_blk_sum[s]),
      .o_c_out (w_blk_cout[s]),
      .o_c_msb (w_blk_cmsb[s])
    );
  end

  always_comb begin
    valid_d[0]            = in_valid;
    sum_d[0]              = '0;
    sum_d[0][BLOCK-1:0]   = w_blk_sum[0];
    carry_d[0]            = w_blk_cout[0];
    cmsb_d[0]             = w_blk_cmsb[0];
    opa_d[0]              = a;
    opb_d[0]              = w_b_eff;
    for (int s = 1; s < NUM_BLK; s++) begin
      valid_d[s]                  = valid_q[s-1];
      sum_d[s]                    = sum_q[s-1];
      sum_d[s][s*BLOCK +: BLOCK]  = w_blk_sum[s];
      carry_d[s]                  = w_blk_cout[s];
      cmsb_d[s]                   = w_blk_cmsb[s];
      opa_d[s]                    = opa_q[s-1];
      opb_d[s]                    = opb_q[s-1];
    end
  end

  // Payload only moves with a valid token, so bubbles never disturb sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_BLK; s++) begin
        valid_q[s] <= 1'b0;
        sum_q[s]   <= '0;
        carry_q[s] <= 1'b0;
        cmsb_q[s]  <= 1'b0;
        opa_q[s]   <= '0;
        opb_q[s]   <= '0;
      end
    end else if (w_advance) begin
      for (int s = 0; s < NUM_BLK; s++) begin
        valid_q[s] <= valid_d[s];
        if (valid_d[s]) begin
          sum_q[s]   <= sum_d[s];
          carry_q[s] <= carry_d[s];
          cmsb_q[s]  <= cmsb_d[s];
          opa_q[s]   <= opa_d[s];
          opb_q[s]   <= opb_d[s];
        end
      end
    end
  end

  assign sum   = sum_q[LAST];
  assign c_out = carry_q[LAST];
  assign ovf   = cmsb_q[LAST] ^ carry_q[LAST];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
// ----------------------------------------------------------------------------
// tb_pipelined_csel_adder: directed checks on the 16/4 adder plus random
// streams on 8/8 and 32/4 instances. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_csel_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [15:0] a, b, sum;

  logic        v8_in_valid, v8_in_ready, v8_c_in, v8_sub, v8_out_valid, v8_out_ready;
  logic        v8_c_out, v8_ovf;
  logic [7:0]  v8_a, v8_b, v8_sum;

  logic        v32_in_valid, v32_in_ready, v32_c_in, v32_sub, v32_out_valid, v32_out_ready;
  logic        v32_c_out, v32_ovf;
  logic [31:0] v32_a, v32_b, v32_sum;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] q8  [$];
  logic [63:0] q32 [$];

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) u_dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .a (a), .b (b), .c_in (c_in), .sub (sub), .out_valid (out_valid),
    .out_ready (out_ready), .sum (sum), .c_out (c_out), .ovf (ovf)
  );

  pipelined_csel_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
    .clk (clk), .rst (rst), .in_valid (v8_in_valid), .in_ready (v8_in_ready),
    .a (v8_a), .b (v8_b), .c_in (v8_c_in), .sub (v8_sub), .out_valid (v8_out_valid),
    .out_ready (v8_out_ready), .sum (v8_sum), .c_out (v8_c_out), .ovf (v8_ovf)
  );

  pipelined_csel_adder #(.WIDTH(32), .BLOCK(4)) u_dut32 (
    .clk (clk), .rst (rst), .in_valid (v32_in_valid), .in_ready (v32_in_ready),
    .a (v32_a), .b (v32_b), .c_in (v32_c_in), .sub (v32_sub), .out_valid (v32_out_valid),
    .out_ready (v32_out_ready), .sum (v32_sum), .c_out (v32_c_out), .ovf (v32_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, c_out, sum} of a + (b ^ sub) + (c_in ^ sub) at width w.
  function automatic logic [63:0] ref_model(input int w, input logic [31:0] ra,
                                            input logic [31:0] rb, input logic rc,
                                            input logic rs);
    logic [31:0] mask, am, be, s;
    logic [32:0] full;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = ra & mask;
    be   = (rs ? ~rb : rb) & mask;
    full = {1'b0, am} + {1'b0, be} + {32'd0, rc ^ rs};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
    return {30'd0, ov, co, s};
  endfunction

  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub, input logic [15:0] esum,
                         input logic ecout, input logic eovf);
    int n;
    a = ta; b = tb_v; c_in = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, " latency"}, 64'(n), 64'd4);
    check_eq({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, " sum"}, 64'(sum), 64'(esum));
    check_eq({tag, " c_out"}, 64'(c_out), 64'(ecout));
    check_eq({tag, " ovf"}, 64'(ovf), 64'(eovf));
    @(posedge clk); #1;
    check_eq({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v8_in_valid = 1'b0; v8_a = '0; v8_b = '0; v8_c_in = 1'b0; v8_sub = 1'b0; v8_out_ready = 1'b1;
    v32_in_valid = 1'b0; v32_a = '0; v32_b = '0; v32_c_in = 1'b0; v32_sub = 1'b0; v32_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset sum", 64'(sum), 64'd0);
    check_eq("reset c_out", 64'(c_out), 64'd0);
    check_eq("reset ovf", 64'(ovf), 64'd0);
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_one("add",       16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_one("carry all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("sub borrow",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    begin : stream_test
      int pushed, popped, cyc;
      logic [15:0] held;
      pushed = 0; popped = 0; cyc = 0; held = '0;
      c_in = 1'b0; sub = 1'b0;
      while (popped < 8 && cyc < 60) begin
        out_ready = (cyc >= 6 && cyc <= 8) ? 1'b0 : 1'b1;
        #1;
        if (cyc >= 6 && cyc <= 8) begin
          check_eq("stall in_ready", 64'(in_ready), 64'd0);
          check_eq("stall out_valid", 64'(out_valid), 64'd1);
          if (cyc == 6) held = sum;
          else check_eq("stall sum hold", 64'(sum), 64'(held));
        end
        if (out_valid && out_ready) begin
          check_eq("stream sum", 64'(sum), 64'(2 * popped));
          popped++;
        end
        in_valid = (pushed < 8);
        a = 16'(pushed);
        b = 16'(pushed);
        if (in_valid && in_ready) pushed++;
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      check_eq("stream count", 64'(popped), 64'd8);
    end

    begin : reset_test
      out_ready = 1'b1; c_in = 1'b0; sub = 1'b0;
      a = 16'd1; b = 16'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'd2; b = 16'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("midrst out_valid", 64'(out_valid), 64'd0);
      check_eq("midrst sum", 64'(sum), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        check_eq("postrst out_valid", 64'(out_valid), 64'd0);
        check_eq("postrst sum", 64'(sum), 64'd0);
      end
      run_one("after rst", 16'd3, 16'd4, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0);
    end

    begin : sweep_test
      int n8, n32, cyc;
      logic [63:0] e;
      n8 = 0; n32 = 0; cyc = 0;
      while ((n8 < 1000 || n32 < 1000 || q8.size() != 0 || q32.size() != 0) && cyc < 6000) begin
        v32_out_ready = (n32 < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (v8_out_valid && v8_out_ready) begin
          if (q8.size() == 0) check_eq("w8 spurious", 64'(v8_out_valid), 64'd0);
          else begin
            e = q8.pop_front();
            check_eq("w8 result", {30'd0, v8_ovf, v8_c_out, 24'd0, v8_sum}, e);
          end
        end
        if (v32_out_valid && v32_out_ready) begin
          if (q32.size() == 0) check_eq("w32 spurious", 64'(v32_out_valid), 64'd0);
          else begin
            e = q32.pop_front();
            check_eq("w32 result", {30'd0, v32_ovf, v32_c_out, v32_sum}, e);
          end
        end
        v8_in_valid = (n8 < 1000) && ($urandom_range(0, 4) != 0);
        v8_a = 8'($urandom); v8_b = 8'($urandom);
        v8_c_in = 1'($urandom); v8_sub = 1'($urandom);
        if (v8_in_valid && v8_in_ready) begin
          q8.push_back(ref_model(8, {24'd0, v8_a}, {24'd0, v8_b}, v8_c_in, v8_sub));
          n8++;
        end
        v32_in_valid = (n32 < 1000) && ($urandom_range(0, 4) != 0);
        v32_a = $urandom; v32_b = $urandom;
        v32_c_in = 1'($urandom); v32_sub = 1'($urandom);
        if (v32_in_valid && v32_in_ready) begin
          q32.push_back(ref_model(32, v32_a, v32_b, v32_c_in, v32_sub));
          n32++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      v8_in_valid = 1'b0;
      v32_in_valid = 1'b0;
      check_eq("w8 drained", 64'(q8.size()), 64'd0);
      check_eq("w32 drained", 64'(q32.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
